// File: rtl/text_console.sv
`timescale 1ns/1ps
// text_console: turns a character/attribute byte stream into cell writes on the
// 80x60 text video RAM port. It keeps a hardware cursor and performs wrap,
// scroll-up and clear-screen as local bus-master sequences.
module text_console #(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic        clk_25mhz,
  input  logic        rst_i,
  input  logic [7:0]  char_i,
  input  logic [7:0]  attr_i,
  input  logic        char_valid_i,
  output logic        char_ready_o,
  output logic [13:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  output logic [6:0]  cursor_col_o,
  output logic [5:0]  cursor_row_o,
  output logic        busy_o
);

  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
  localparam logic [12:0] ROW_STEP  = 13'(COLS);
  localparam logic [12:0] LAST_COPY = 13'(COLS * (ROWS - 1) - 1);
  localparam logic [12:0] LAST_CELL = 13'(COLS * ROWS - 1);

  typedef enum logic [3:0] {
    IDLE, DISPATCH, PUT_CH, PUT_COL,
    SCR_RD_C, SCR_WT_C, SCR_WR_C,
    SCR_RD_A, SCR_WT_A, SCR_WR_A,
    CLR_C, CLR_A
  } state_t;

  state_t      state, state_n;
  logic        ackd, ackd_n;     // write already acknowledged; stb low this cycle
  logic [6:0]  col, col_n;
  logic [5:0]  row, row_n;
  logic [12:0] idx, idx_n;       // scroll/clear cell counter
  logic        ff_q, ff_n;       // clear came from FF: home the cursor at the end
  logic        bs_q, bs_n;       // cell write came from BS: no cursor advance
  logic [7:0]  ch_q, ch_n;
  logic [7:0]  attr_q, attr_n;
  logic [7:0]  rd_q, rd_n;       // byte fetched during a scroll copy
  logic [12:0] cell_idx;
  logic [12:0] src_idx;
  logic [7:0]  wr_byte;
  logic        drv;

  // row*80 + col built from shifts so no multiplier is needed
  assign cell_idx = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {6'b0, col};
  assign src_idx  = idx + ROW_STEP;

  assign char_ready_o = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign cursor_col_o = col;
  assign cursor_row_o = row;

  // next-state, cursor update and bus drive decoding
  always_comb begin
    state_n = state;
    ackd_n  = ackd;
    col_n   = col;
    row_n   = row;
    idx_n   = idx;
    ff_n    = ff_q;
    bs_n    = bs_q;
    ch_n    = ch_q;
    attr_n  = attr_q;
    rd_n    = rd_q;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_adr_o = '0;
    wr_byte = '0;
    drv     = 1'b0;

    unique case (state)
      IDLE: begin
        if (char_valid_i) begin
          ch_n    = char_i;
          attr_n  = attr_i;
          state_n = DISPATCH;
        end
      end
      DISPATCH: begin
        state_n = IDLE;
        unique case (ch_q)
          8'h0D: col_n = '0;
          8'h0A: begin
            if (row < LAST_ROW) row_n = row + 6'd1;
            else begin
              idx_n   = '0;
              ff_n    = 1'b0;
              state_n = SCR_RD_C;
            end
          end
          8'h08: begin
            if (col != '0) begin
              col_n   = col - 7'd1;
              ch_n    = 8'h20;
              bs_n    = 1'b1;
              state_n = PUT_CH;
            end
          end
          8'h0C: begin
            idx_n   = '0;
            ff_n    = 1'b1;
            state_n = CLR_C;
          end
          default: begin
            bs_n    = 1'b0;
            state_n = PUT_CH;
          end
        endcase
      end
      PUT_CH: begin
        drv     = 1'b1;
        m_we_o  = 1'b1;
        m_stb_o = !ackd;
        m_adr_o = {1'b0, cell_idx};
        wr_byte = ch_q;
        ackd_n  = !ackd && m_ack_i;
        if (ackd) state_n = PUT_COL;
      end
      PUT_COL: begin
        drv     = 1'b1;
        m_we_o  = 1'b1;
        m_stb_o = !ackd;
        m_adr_o = {1'b1, cell_idx};
        wr_byte = attr_q;
        ackd_n  = !ackd && m_ack_i;
        if (ackd) begin
          state_n = IDLE;
          if (!bs_q) begin
            if (col == LAST_COL) begin
              col_n = '0;
              if (row < LAST_ROW) row_n = row + 6'd1;
              else begin
                idx_n   = '0;
                ff_n    = 1'b0;
                state_n = SCR_RD_C;
              end
            end else begin
              col_n = col + 7'd1;
            end
          end
        end
      end
      SCR_RD_C: begin
        drv     = 1'b1;
        m_stb_o = 1'b1;
        m_adr_o = {1'b0, src_idx};
        if (m_ack_i) state_n = SCR_WT_C;
      end
      SCR_WT_C: begin
        rd_n    = m_dat_i[{src_idx[1:0], 3'b000} +: 8];
        state_n = SCR_WR_C;
      end
      SCR_WR_C: begin
        drv     = 1'b1;
        m_we_o  = 1'b1;
        m_stb_o = !ackd;
        m_adr_o = {1'b0, idx};
        wr_byte = rd_q;
        ackd_n  = !ackd && m_ack_i;
        if (ackd) state_n = SCR_RD_A;
      end
      SCR_RD_A: begin
        drv     = 1'b1;
        m_stb_o = 1'b1;
        m_adr_o = {1'b1, src_idx};
        if (m_ack_i) state_n = SCR_WT_A;
      end
      SCR_WT_A: begin
        rd_n    = m_dat_i[{src_idx[1:0], 3'b000} +: 8];
        state_n = SCR_WR_A;
      end
      SCR_WR_A: begin
        drv     = 1'b1;
        m_we_o  = 1'b1;
        m_stb_o = !ackd;
        m_adr_o = {1'b1, idx};
        wr_byte = rd_q;
        ackd_n  = !ackd && m_ack_i;
        if (ackd) begin
          idx_n   = idx + 13'd1;
          state_n = (idx == LAST_COPY) ? CLR_C : SCR_RD_C;
        end
      end
      CLR_C: begin
        drv     = 1'b1;
        m_we_o  = 1'b1;
        m_stb_o = !ackd;
        m_adr_o = {1'b0, idx};
        wr_byte = 8'h20;
        ackd_n  = !ackd && m_ack_i;
        if (ackd) state_n = CLR_A;
      end
      CLR_A: begin
        drv     = 1'b1;
        m_we_o  = 1'b1;
        m_stb_o = !ackd;
        m_adr_o = {1'b1, idx};
        wr_byte = attr_q;
        ackd_n  = !ackd && m_ack_i;
        if (ackd) begin
          if (idx == LAST_CELL) begin
            state_n = IDLE;
            if (ff_q) begin
              col_n = '0;
              row_n = '0;
            end
          end else begin
            idx_n   = idx + 13'd1;
            state_n = CLR_C;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    m_sel_o = drv ? (4'b0001 << m_adr_o[1:0]) : 4'b0000;
    m_dat_o = {4{wr_byte}};
  end

  // control state and cursor; reset aborts any sequence in flight
  always_ff @(posedge clk_25mhz) begin
    if (!rst_i) begin
      state <= IDLE;
      ackd  <= 1'b0;
      col   <= '0;
      row   <= '0;
      idx   <= '0;
      ff_q  <= 1'b0;
      bs_q  <= 1'b0;
    end else begin
      state <= state_n;
      ackd  <= ackd_n;
      col   <= col_n;
      row   <= row_n;
      idx   <= idx_n;
      ff_q  <= ff_n;
      bs_q  <= bs_n;
    end
  end

  // data holding registers for the current byte and the scroll copy
  always_ff @(posedge clk_25mhz) begin
    ch_q   <= ch_n;
    attr_q <= attr_n;
    rd_q   <= rd_n;
  end

endmodule
